// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiply (i_div=0) or restoring shift-subtract divide (i_div=1).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Remainder stays below the divisor, so the W-bit difference is exact whenever w_ge.
  always_comb begin
    w_sum    = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opnd} : '0);
    w_shl    = {i_acc_hi, i_acc_lo[WIDTH-1]};
    w_ge     = (w_shl >= {1'b0, i_opnd});
    w_diff   = w_shl[WIDTH-1:0] - i_opnd;
    o_acc_hi = w_sum[WIDTH:1];
    o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
    if (i_div) begin
      o_acc_hi = w_ge ? w_diff : w_shl[WIDTH-1:0];
      o_acc_lo = {i_acc_lo[WIDTH-2:0], w_ge};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: iterative magnitude datapath with sign fix-up, owns HI/LO.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational MULT/MULTU path.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done;

  logic             w_arith, w_is_div, w_is_signed, w_rs_neg, w_rt_neg, w_fast;
  logic [WIDTH-1:0] w_rs_mag, w_rt_mag, w_step_hi, w_step_lo;
  logic [PW-1:0]    w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_arith     = ~op[2];
  assign w_is_div    = op[1];
  assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_rs_neg    = w_is_signed & rs_data[WIDTH-1];
  assign w_rt_neg    = w_is_signed & rt_data[WIDTH-1];
  assign w_rs_mag    = w_rs_neg ? (~rs_data + WIDTH'(1)) : rs_data;
  assign w_rt_mag    = w_rt_neg ? (~rt_data + WIDTH'(1)) : rt_data;

`ifdef MULDIV_FAST_MULT_EN
  logic [PW-1:0] w_fast_prod;
  assign w_fast_prod = PW'(w_rs_mag) * PW'(w_rt_mag);
  assign w_fast      = ~w_is_div;
`else
  assign w_fast      = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div    (r_div),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_opnd   (r_opnd),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo)
  );

  // Sign fix-up; divide-by-zero quotient is forced, its remainder falls out of the sign rule.
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
  assign w_quo      = r_dz ? '1 : (r_neg_q ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo);
  assign w_rem      = r_neg_r ? (~r_acc_hi + WIDTH'(1)) : r_acc_hi;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && w_arith) w_state_nxt = w_fast ? ST_FIX : ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE: begin
          if (start && w_arith) begin
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_div    <= w_is_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_is_div & w_rs_neg;
            r_dz     <= w_is_div & (rt_data == '0);
            r_acc_hi <= '0;
            r_acc_lo <= w_is_div ? w_rs_mag : w_rt_mag;
            r_opnd   <= w_is_div ? w_rt_mag : w_rs_mag;
`ifdef MULDIV_FAST_MULT_EN
            if (!w_is_div) {r_acc_hi, r_acc_lo} <= w_fast_prod;
`endif
          end else if (start && (op == OP_MTHI)) begin
            r_hi <= rs_data;
          end else if (start && (op == OP_MTLO)) begin
            r_lo <= rs_data;
          end
        end
        ST_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIX: begin
          r_busy <= 1'b0;
          r_hi   <= r_div ? w_rem : w_prod_fix[PW-1:WIDTH];
          r_lo   <= r_div ? w_quo : w_prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl; outputs sampled on the falling edge.
module tb_hilo_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_DONE_K = 2;
  localparam int MUL_BUSY_N = 1;
`else
  localparam int MUL_DONE_K = 34;
  localparam int MUL_BUSY_N = 33;
`endif

  hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Start is sampled at the posedge between the two falling edges; returns at sample k=1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    ok = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (hi !== 32'h0)   begin n_errors++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0)   begin n_errors++; $display("FAIL reset_lo got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0)  begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_multu_latency;
    int first_done = 0, n_busy = 0, n_done = 0;
    logic [31:0] hi_mid = '1;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 40; k++) begin
      if (busy) n_busy++;
      if (done) begin n_done++; if (first_done == 0) first_done = k; end
      if (k == 10) hi_mid = hi;
      @(negedge clk);
    end
    n_checks++; if (first_done !== MUL_DONE_K) begin n_errors++; $display("FAIL multu_done_cycle got %0d want %0d", first_done, MUL_DONE_K); end
    n_checks++; if (n_busy !== MUL_BUSY_N) begin n_errors++; $display("FAIL multu_busy_cycles got %0d want %0d", n_busy, MUL_BUSY_N); end
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL multu_done_pulses got %0d want 1", n_done); end
`ifndef MULDIV_FAST_MULT_EN
    n_checks++; if (hi_mid !== 32'h0) begin n_errors++; $display("FAIL multu_hi_during_run got %h want 0", hi_mid); end
`endif
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_checks++; if (lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_signed;
    bit ok;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL mult_timeout got done=%b want 1", done); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_errors++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL div_timeout got done=%b want 1", done); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
  endtask

  task automatic test_div_edges;
    bit ok;
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL divu0_timeout got done=%b want 1", done); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL divu0_lo got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'd7) begin n_errors++; $display("FAIL divu0_hi got %h want 00000007", hi); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(ok);
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFF9) begin n_errors++; $display("FAIL div0_hi got %h want fffffff9", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL divovf_timeout got done=%b want 1", done); end
    n_checks++; if (lo !== 32'h8000_0000) begin n_errors++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL divovf_hi got %h want 0", hi); end
  endtask

  task automatic test_mthi_mtlo;
    // lo holds 0x80000000 from the preceding overflow divide
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_checks++; if (lo !== 32'h8000_0000) begin n_errors++; $display("FAIL mthi_lo got %h want 80000000", lo); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mthi_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mthi_done got %b want 0", done); end
    issue(OP_MTLO, 32'hCAFE_BABE, 32'h0);
    n_checks++; if (lo !== 32'hCAFE_BABE) begin n_errors++; $display("FAIL mtlo_lo got %h want cafebabe", lo); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL mtlo_hi got %h want 12345678", hi); end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTLO; rs_data = 32'h0000_DEAD; rt_data = 32'h0;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (lo !== 32'hCAFE_BABE) begin n_errors++; $display("FAIL busy_mtlo_lo got %h want cafebabe", lo); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL divu_timeout got done=%b want 1", done); end
    n_checks++; if (lo !== 32'd14) begin n_errors++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_checks++; if (hi !== 32'd2) begin n_errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    issue(OP_DIVU, 32'd50, 32'd8);
    wait_done(ok);
    n_checks++; if (lo !== 32'd6 || hi !== 32'd2) begin n_errors++; $display("FAIL b2b_first got hi=%h lo=%h want hi=2 lo=6", hi, lo); end
    start = 1'b1; op = OP_MULTU; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_timeout got done=%b want 1", done); end
    n_checks++; if (lo !== 32'd42 || hi !== 32'd0) begin n_errors++; $display("FAIL b2b_second got hi=%h lo=%h want hi=0 lo=2a", hi, lo); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n_done = 0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_errors++; $display("FAIL rstmid_hilo got hi=%h lo=%h want 0", hi, lo); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_checks++; if (n_done !== 0 || hi !== 32'h0 || lo !== 32'h0) begin n_errors++; $display("FAIL rstmid_no_done got pulses=%0d hi=%h lo=%h want 0", n_done, hi, lo); end
    issue(OP_DIVU, 32'd9, 32'd3);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rstmid_div_timeout got done=%b want 1", done); end
    n_checks++; if (lo !== 32'd3 || hi !== 32'd0) begin n_errors++; $display("FAIL rstmid_div got hi=%h lo=%h want hi=0 lo=3", hi, lo); end
  endtask

  initial begin
    test_reset;
    test_multu_latency;
    test_signed;
    test_div_edges;
    test_mthi_mtlo;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
